// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_ctrl_pkg;
  localparam int DEF_WIDTH  = 32;
  localparam int ITER_COUNT = DEF_WIDTH;
  localparam int CNT_W      = $clog2(DEF_WIDTH);
  localparam logic [DEF_WIDTH-1:0] DZ_RESULT = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ITER  = 3'd1,
    FIXUP = 3'd2,
    SIGN  = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle between the control unit and the divider.
interface div_seq_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic             kill;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, kill, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, kill, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One non-restoring divide iteration: shift in the next dividend bit, then add or subtract |b|.
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] p_sh;

  always_comb begin
    p_sh   = {p[WIDTH-1:0], q[WIDTH-1]};
    p_next = p_sh[WIDTH] ? (p_sh + {1'b0, b_mag}) : (p_sh - {1'b0, b_mag});
    q_next = {q[WIDTH-2:0], ~p_next[WIDTH]};
  end
endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed divide controller: one quotient bit per clock, truncating division.
module div_seq_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  div_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             dz_pend;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b_mag;
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH:0]   p_nx;
  logic [WIDTH-1:0] q_nx;
  logic             accept;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? neg(x) : x;
  endfunction

  assign accept = (state == IDLE) && bus.start && !bus.kill;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p),
    .q      (q),
    .b_mag  (b_mag),
    .p_next (p_nx),
    .q_next (q_nx)
  );

  // Datapath: operand capture, iteration, final remainder restore
  always_ff @(posedge clk) begin
    if (accept) begin
      p      <= '0;
      q      <= mag(bus.dividend);
      b_mag  <= mag(bus.divisor);
      sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      sign_r <= bus.dividend[WIDTH-1];
    end else if (state == ITER) begin
      p <= p_nx;
      q <= q_nx;
    end else if (state == FIXUP && p[WIDTH]) begin
      p <= p + {1'b0, b_mag};
    end
  end

  // Control FSM with registered outputs; divide-by-zero spends two cycles in DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      dz_pend         <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.kill && state != IDLE) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
        dz_pend  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (bus.divisor == '0) begin
                state   <= DONE;
                dz_pend <= 1'b1;
              end else begin
                state    <= ITER;
                bus.busy <= 1'b1;
                cnt      <= CW'(WIDTH - 1);
              end
            end
          end
          ITER: begin
            cnt <= cnt - CW'(1);
            if (cnt == '0) state <= FIXUP;
          end
          FIXUP: state <= SIGN;
          SIGN: begin
            bus.quotient    <= sign_q ? neg(q) : q;
            bus.remainder   <= sign_r ? neg(p[WIDTH-1:0]) : p[WIDTH-1:0];
            bus.div_by_zero <= 1'b0;
            bus.done        <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= DONE;
          end
          DONE: begin
            if (dz_pend) begin
              bus.quotient    <= '1;
              bus.remainder   <= '1;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
              dz_pend         <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed plus randomized bench for div_seq_ctrl against an arithmetic reference model.
module tb_div_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  div_seq_ctrl_if #(.WIDTH(32)) bus ();

  div_seq_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eq, output logic [31:0] er,
                                output logic edz);
    longint sa, sb;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = 32'hFFFF_FFFF;
      edz = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      eq = 32'(sa / sb);
      er = 32'(sa % sb);
      edz = 1'b0;
    end
  endfunction

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  // Starts a divide and checks latency, busy behaviour, results and single-pulse done.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    logic edz;
    int n, busy_cnt;
    model(a, b, eq, er, edz);
    pulse_start(a, b);
    busy_cnt = bus.busy ? 1 : 0;
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.done) begin
        n = i;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
    check({tag, "_latency"}, 64'(n), edz ? 64'd1 : 64'd34);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), edz ? 64'd0 : 64'd34);
    check({tag, "_quotient"}, 64'(bus.quotient), 64'(eq));
    check({tag, "_remainder"}, 64'(bus.remainder), 64'(er));
    check({tag, "_dz"}, 64'(bus.div_by_zero), 64'(edz));
    tick();
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_held_q"}, 64'(bus.quotient), 64'(eq));
  endtask

  task automatic count_dones(input int cycles, output int dones);
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.done) dones++;
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    int dones;
    bus.start = 1'b0;
    bus.kill = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_quotient", 64'(bus.quotient), 64'd0);
    check("rst_remainder", 64'(bus.remainder), 64'd0);
    check("rst_dz", 64'(bus.div_by_zero), 64'd0);
    rst_n = 1'b1;
    tick();

    run_div("pos_pos", 32'd100, 32'd7);
    run_div("neg_pos", 32'hFFFF_FF9C, 32'd7);
    run_div("pos_neg", 32'd100, 32'hFFFF_FFF9);
    run_div("div_zero", 32'd100, 32'd0);
    run_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("zero_num", 32'd0, 32'd5);
    run_div("min_by_min", 32'h8000_0000, 32'h8000_0000);
    run_div("small_by_min", 32'd5, 32'h8000_0000);

    for (int k = 0; k < 20; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 40)) - 32'd20;
        1: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_div("random", ra, rb);
    end

    // A second start while busy must be dropped
    pulse_start(32'd9, 32'd2);
    repeat (4) tick();
    pulse_start(32'd50, 32'd5);
    count_dones(45, dones);
    check("busy_start_dones", 64'(dones), 64'd1);
    check("busy_start_q", 64'(bus.quotient), 64'd4);
    check("busy_start_r", 64'(bus.remainder), 64'd1);

    // Kill mid-iteration: no done, results held, then a fresh start works
    pulse_start(32'd100, 32'd7);
    repeat (10) tick();
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    check("kill_busy", 64'(bus.busy), 64'd0);
    check("kill_done", 64'(bus.done), 64'd0);
    check("kill_held_q", 64'(bus.quotient), 64'd4);
    check("kill_held_r", 64'(bus.remainder), 64'd1);
    run_div("after_kill", 32'd9, 32'd3);

    // Kill and start together in IDLE: start dropped
    bus.kill = 1'b1;
    pulse_start(32'd77, 32'd3);
    bus.kill = 1'b0;
    check("kill_start_busy", 64'(bus.busy), 64'd0);
    count_dones(40, dones);
    check("kill_start_dones", 64'(dones), 64'd0);

    // Reset mid-iteration clears outputs and suppresses done
    pulse_start(32'd100, 32'd7);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_q", 64'(bus.quotient), 64'd0);
    check("midrst_r", 64'(bus.remainder), 64'd0);
    check("midrst_dz", 64'(bus.div_by_zero), 64'd0);
    count_dones(40, dones);
    check("midrst_dones", 64'(dones), 64'd0);
    run_div("after_rst", 32'hFFFF_FFF7, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle signed divide controller for the MiniSRC ALU; sequences an iterative non-restoring divide at one quotient bit per clock.
- Accepts a divide request from the control unit, runs the iteration, restores the remainder and applies sign fixups.
- Returns quotient (LO) and remainder (HI) with a one-cycle done pulse.
- Replaces the single-cycle combinational divide path, removing it from the critical path.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request pulse; sampled only when busy=0
- kill  input  1  pipeline flush; aborts any in-flight divide
- dividend  input  WIDTH  signed a; sampled on accepted start
- divisor  input  WIDTH  signed b; sampled on accepted start
- busy  output  1  high from the cycle after start acceptance until done or abort
- done  output  1  one-cycle pulse; quotient/remainder valid
- quotient  output  WIDTH  signed quotient, held until the next done
- remainder  output  WIDTH  signed remainder, held until the next done
- div_by_zero  output  1  set with done when divisor==0; held with results

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low (rst_n sampled at the clk edge).
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- States: IDLE, ITER, FIXUP, SIGN, DONE.
- IDLE: start=1 at edge E0 latches the following:
  - |a| and |b| as two's-complement magnitudes (0x80000000 maps to itself as unsigned);
  - sign_q = a[31]^b[31];
  - sign_r = a[31].
  - Clears the 33-bit partial remainder P and loads Q=|a|.
  - divisor==0: go to DONE, skipping the iteration.
  - Otherwise: go to ITER with counter=WIDTH-1.
- ITER, one bit per cycle:
  - P={P[31:0],Q[31]};
  - if P[32]==0 then P=P-|b|, else P=P+|b|;
  - Q={Q[30:0],~P[32]};
  - decrement counter; after the counter==0 cycle go to FIXUP. ITER occupies exactly WIDTH cycles.
- FIXUP: if P[32]==1 then P=P+|b|. Go to SIGN.
- SIGN:
  - quotient = sign_q ? -Q : Q;
  - remainder = sign_r ? -P[31:0] : P[31:0];
  - div_by_zero=0. Go to DONE.
- DONE:
  - done=1 for this single cycle, then IDLE.
  - Divide-by-zero path: quotient=remainder=all ones, div_by_zero=1.
- Latency:
  - normal divide: done high in the cycle after edge E0+WIDTH+2 (34 cycles for WIDTH=32);
  - divide-by-zero: done high after edge E0+1.
- busy is high in ITER, FIXUP and SIGN only. busy is low in IDLE and DONE.
- start in DONE is ignored. start while busy is ignored, with no queuing.
- kill (any non-IDLE state):
  - next state IDLE, busy=0, no done;
  - quotient, remainder and div_by_zero keep their previous values.
- Simultaneous kill and start in IDLE: kill wins and start is dropped.
- Reset mid-operation: all outputs return to reset values; no done is produced.
- Overflow case 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, no flag.
- Remainder always takes the dividend's sign (truncating division); |remainder| < |divisor|.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- div_ctrl_pkg holds:
  - state enum (IDLE, ITER, FIXUP, SIGN, DONE);
  - ITER_COUNT=WIDTH;
  - DZ_RESULT=all ones;
  - counter width $clog2(WIDTH).
- One natural sub-module, div_step: combinational single non-restoring iteration.
  - Inputs: P, Q, |b|. Outputs: next P, next Q.
  - Instantiated once and reused each ITER cycle.
- Magnitude/negation is inline two's-complement logic, not a separate instance.

Test Plan:
- 100 / 7, start pulse in IDLE -> busy one cycle later; done after 34 cycles; quotient=14, remainder=2, div_by_zero=0.
- -100 (0xFFFFFF9C) / 7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); 100 / -7 -> quotient=-14, remainder=2.
- 100 / 0 -> done after 1 cycle, quotient=remainder=0xFFFFFFFF, div_by_zero=1, busy never high.
- 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; 0 / 5 -> quotient=0, remainder=0.
- start 9/2, then start 50/5 at cycle 5 while busy -> second start ignored; single done with quotient=4, remainder=1.
- kill at ITER cycle 10 -> busy low next cycle, no done, prior results held; new start 9/3 accepted next cycle -> quotient=3, remainder=0. Repeat with rst_n low mid-ITER -> outputs cleared, no done.
